// File: rtl/vx_mem_line_serializer.sv
// vx_mem_line_serializer: splits memory-line requests into 32-bit word bus accesses and
// reassembles read words into a line-wide response.
`ifndef VX_MEM_ADDR_WIDTH
`define VX_MEM_ADDR_WIDTH 26
`endif
`ifndef VX_MEM_TAG_WIDTH
`define VX_MEM_TAG_WIDTH 8
`endif
module vx_mem_line_serializer #(
  parameter int LINE_WORDS = 16,
  parameter int ADDR_WIDTH = `VX_MEM_ADDR_WIDTH,
  parameter int TAG_WIDTH  = `VX_MEM_TAG_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [4*LINE_WORDS-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [32*LINE_WORDS-1:0] mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [32*LINE_WORDS-1:0] mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic [31:0]             gb_addr,
  output logic                    gb_ren,
  output logic                    gb_wen,
  output logic [31:0]             gb_wdata,
  output logic [3:0]              gb_byte_en,
  input  logic [31:0]             gb_rdata,
  input  logic                    gb_busy,
  output logic                    busy
);
  localparam int IW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, XFER, RSP} state_e;
  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    rw_q;
  logic [4*LINE_WORDS-1:0] byteen_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [32*LINE_WORDS-1:0] data_q, rbuf_q;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic                    hs, word_done, last;
  logic [3:0]              slice;
  assign hs    = mem_req_valid & mem_req_ready;
  assign slice = byteen_q[idx_q*4 +: 4];
  assign last  = idx_q == IW'(LINE_WORDS - 1);
  // A write word with no enabled bytes never touches the bus, so it ignores gb_busy.
  assign word_done = (state_q == XFER) & (~gb_busy | (rw_q & (slice == 4'h0)));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end
  always_comb begin
    idx_d   = hs ? '0 : word_done ? idx_q + 1'b1 : idx_q;
    state_d = hs ? XFER
            : (word_done & last) ? (rw_q ? IDLE : RSP)
            : (state_q == RSP & mem_rsp_ready) ? IDLE
            : state_q;
  end
  always_comb begin
    mem_req_ready = (state_q == IDLE) & ~reset;
    busy          = state_q != IDLE;
    mem_rsp_valid = state_q == RSP;
    mem_rsp_data  = rbuf_q;
    mem_rsp_tag   = tag_q;
    gb_ren        = (state_q == XFER) & ~rw_q;
    gb_wen        = (state_q == XFER) & rw_q & (slice != 4'h0);
    gb_byte_en    = gb_wen ? slice : gb_ren ? 4'hF : 4'h0;
    gb_wdata      = data_q[idx_q*32 +: 32];
    gb_addr       = 32'({addr_q, idx_q, 2'b00});
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q     <= 1'b0;
      byteen_q <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      tag_q    <= '0;
      rbuf_q   <= '0;
    end else begin
      if (hs) begin
        rw_q     <= mem_req_rw;
        byteen_q <= mem_req_byteen;
        addr_q   <= mem_req_addr;
        data_q   <= mem_req_data;
        tag_q    <= mem_req_tag;
      end
      if (word_done & ~rw_q) rbuf_q[idx_q*32 +: 32] <= gb_rdata;
    end
  end
endmodule

// File: tb/tb_vx_mem_line_serializer.sv
// tb_vx_mem_line_serializer: scenario tasks driving line requests and comparing bus traffic
// and responses against a per-word access model built from the line request.
`timescale 1ns/1ps
module tb_vx_mem_line_serializer;
  localparam int LW = 16, AW = 26, TW = 8, DW = 32*LW;
  typedef struct packed {logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; logic we;} acc_t;
  logic clk = 1'b0, reset;
  logic mem_req_valid, mem_req_rw, mem_req_ready, mem_rsp_valid, mem_rsp_ready;
  logic [4*LW-1:0] mem_req_byteen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data, mem_rsp_data;
  logic [TW-1:0] mem_req_tag, mem_rsp_tag;
  logic [31:0] gb_addr, gb_wdata, gb_rdata;
  logic gb_ren, gb_wen, gb_busy, busy;
  logic [3:0] gb_byte_en;
  logic [31:0] rd_xor = 0, rd_add = 0;
  int checks = 0, errors = 0;
  acc_t obs[$], exp_q[$];
  int end_cycle, rsp_cycle, wait_cycles, stall_word = 0, stall_len = 0, busy_pct = 0, rsp_wait = 0;
  bit strobe_bad, stall_bad, rsp_bad, ready_cons, ready_after, got_rsp, timeout, chain = 0;
  logic [DW-1:0] rsp_data_obs, nxt_data;
  logic [TW-1:0] rsp_tag_obs, nxt_tag;
  logic [AW-1:0] nxt_addr;
  logic [4*LW-1:0] nxt_byteen;
  logic nxt_rw;

  always #5 clk = ~clk;
  // Bus memory: each word address returns a value derived from it.
  assign gb_rdata = rd_xor ^ (rd_add + {2'b00, gb_addr[31:2]});

  vx_mem_line_serializer #(.LINE_WORDS(LW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .gb_addr(gb_addr), .gb_ren(gb_ren), .gb_wen(gb_wen), .gb_wdata(gb_wdata),
    .gb_byte_en(gb_byte_en), .gb_rdata(gb_rdata), .gb_busy(gb_busy), .busy(busy));

  function automatic void build_exp(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                    input logic [4*LW-1:0] be);
    logic [31:0] wa;
    exp_q.delete();
    for (int i = 0; i < LW; i++) begin
      wa = {a, 6'b0} + 32'(4*i);
      if (!rw) exp_q.push_back('{wa, 32'h0, 4'hF, 1'b0});
      else if (be[4*i +: 4] != 4'h0) exp_q.push_back('{wa, d[32*i +: 32], be[4*i +: 4], 1'b1});
    end
  endfunction

  function automatic logic [DW-1:0] exp_line(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < LW; i++) r[32*i +: 32] = rd_xor ^ (rd_add + 32'({a, 4'b0}) + 32'(i));
    return r;
  endfunction

  // Drives one request (entered at a negedge) and records everything seen until idle again.
  task automatic run_txn(input logic rw, input logic [AW-1:0] a, input logic [TW-1:0] t,
                         input logic [DW-1:0] d, input logic [4*LW-1:0] be);
    int hold, scnt;
    bit pstall;
    logic [69:0] snap, psnap;
    obs.delete();
    {strobe_bad, stall_bad, rsp_bad, ready_cons, ready_after, got_rsp, timeout, pstall} = '0;
    rsp_cycle = -1; end_cycle = -1; hold = 0; scnt = 0; wait_cycles = 0; psnap = '0;
    mem_req_valid = 1; mem_req_rw = rw; mem_req_addr = a; mem_req_tag = t;
    mem_req_data = d; mem_req_byteen = be; gb_busy = 0; mem_rsp_ready = 0;
    while (!mem_req_ready && wait_cycles < 50) begin @(negedge clk); wait_cycles++; end
    if (!mem_req_ready) begin timeout = 1; mem_req_valid = 0; return; end
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (chain) begin
          mem_req_rw = nxt_rw; mem_req_addr = nxt_addr; mem_req_tag = nxt_tag;
          mem_req_data = nxt_data; mem_req_byteen = nxt_byteen;
        end else mem_req_valid = 0;
      end
      if (!busy) begin end_cycle = c; ready_after = mem_req_ready; break; end
      snap = {gb_ren, gb_wen, gb_addr, gb_byte_en, gb_wdata};
      if (pstall && snap !== psnap) stall_bad = 1;
      if ((gb_ren && gb_wen) || (mem_rsp_valid && (gb_ren || gb_wen))) strobe_bad = 1;
      if ((gb_ren || gb_wen) && gb_addr[5:2] == 4'(stall_word) && scnt < stall_len) begin
        gb_busy = 1; scnt++;
      end else gb_busy = busy_pct > 0 && $urandom_range(99) < busy_pct;
      if ((gb_ren || gb_wen) && !gb_busy)
        obs.push_back('{gb_addr, gb_wen ? gb_wdata : 32'h0, gb_byte_en, gb_wen});
      pstall = (gb_ren || gb_wen) && gb_busy; psnap = snap;
      if (mem_rsp_valid) begin
        if (!got_rsp) begin
          got_rsp = 1; rsp_cycle = c; rsp_data_obs = mem_rsp_data; rsp_tag_obs = mem_rsp_tag;
        end else if (mem_rsp_data !== rsp_data_obs || mem_rsp_tag !== rsp_tag_obs) rsp_bad = 1;
        mem_rsp_ready = hold >= rsp_wait;
        if (mem_rsp_ready) ready_cons = mem_req_ready;
        hold++;
      end else mem_rsp_ready = 0;
      if (c == 1000) timeout = 1;
    end
    gb_busy = 0; mem_rsp_ready = 0;
  endtask

  task automatic test_reset;
    reset = 1; mem_req_valid = 0; mem_req_rw = 0; mem_req_byteen = '0; mem_req_addr = '0;
    mem_req_data = '0; mem_req_tag = '0; mem_rsp_ready = 0; gb_busy = 0;
    repeat (2) @(negedge clk);
    checks++; if (mem_req_ready !== 1'b0) begin errors++; $display("FAIL reset ready: got %b want 0", mem_req_ready); end
    checks++; if ({busy, mem_rsp_valid, gb_ren, gb_wen} !== 4'b0) begin errors++; $display("FAIL reset flags: got %b want 0000", {busy, mem_rsp_valid, gb_ren, gb_wen}); end
    checks++; if (mem_rsp_data !== '0 || mem_rsp_tag !== '0) begin errors++; $display("FAIL reset rsp regs: got %h/%h want 0", mem_rsp_data, mem_rsp_tag); end
    reset = 0;
    @(negedge clk);
    checks++; if (mem_req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset release: ready=%b busy=%b want 1 0", mem_req_ready, busy); end
  endtask

  task automatic test_read_basic;
    logic [DW-1:0] want;
    for (int i = 0; i < LW; i++) want[32*i +: 32] = 32'hA0 + 32'(i);
    rd_xor = 0; rd_add = 32'hFFFFFFA0; busy_pct = 0; stall_len = 0; rsp_wait = 0;
    build_exp(0, 26'h10, '0, '0);
    run_txn(0, 26'h10, 8'd5, '0, '0);
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL read_basic count: got %0d want %0d", obs.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL read_basic acc%0d: got %h want %h", i, obs[i], exp_q[i]); end end
    checks++; if (rsp_cycle !== 17) begin errors++; $display("FAIL read_basic rsp_cycle: got %0d want 17", rsp_cycle); end
    checks++; if (rsp_data_obs !== want) begin errors++; $display("FAIL read_basic data: got %h want %h", rsp_data_obs, want); end
    checks++; if (rsp_tag_obs !== 8'd5) begin errors++; $display("FAIL read_basic tag: got %h want 05", rsp_tag_obs); end
    checks++; if (end_cycle !== 18 || strobe_bad) begin errors++; $display("FAIL read_basic end: got %0d bad=%b want 18 0", end_cycle, strobe_bad); end
  endtask

  task automatic test_write_full;
    logic [DW-1:0] d;
    for (int i = 0; i < LW; i++) d[32*i +: 32] = 32'(i);
    busy_pct = 0; stall_len = 0;
    build_exp(1, 26'h2345, d, '1);
    run_txn(1, 26'h2345, 8'h3C, d, '1);
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL write_full count: got %0d want %0d", obs.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL write_full acc%0d: got %h want %h", i, obs[i], exp_q[i]); end end
    checks++; if (got_rsp !== 1'b0) begin errors++; $display("FAIL write_full rsp: got %b want 0", got_rsp); end
    checks++; if (end_cycle !== 17 || ready_after !== 1'b1) begin errors++; $display("FAIL write_full ready: cycle %0d ready %b want 17 1", end_cycle, ready_after); end
  endtask

  task automatic test_write_sparse;
    logic [DW-1:0] d;
    logic [4*LW-1:0] be;
    for (int i = 0; i < LW; i++) d[32*i +: 32] = $urandom;
    be = '0; be[15:12] = 4'b0110;
    busy_pct = 0; stall_len = 0;
    build_exp(1, 26'h155, d, be);
    run_txn(1, 26'h155, 8'h11, d, be);
    checks++; if (obs.size() != 1) begin errors++; $display("FAIL write_sparse count: got %0d want 1", obs.size()); end
    else begin checks++; if (obs[0] !== exp_q[0]) begin errors++; $display("FAIL write_sparse acc: got %h want %h", obs[0], exp_q[0]); end end
    checks++; if (end_cycle !== 17 || got_rsp) begin errors++; $display("FAIL write_sparse timing: end %0d rsp %b want 17 0", end_cycle, got_rsp); end
    // skipped words must not wait on a busy bus
    busy_pct = 100;
    run_txn(1, 26'h155, 8'h12, d, '0);
    checks++; if (obs.size() != 0 || end_cycle !== 17) begin errors++; $display("FAIL write_skip_busy: accesses %0d end %0d want 0 17", obs.size(), end_cycle); end
    busy_pct = 0;
  endtask

  task automatic test_stall_rsp;
    logic [AW-1:0] a;
    a = AW'($urandom); rd_xor = $urandom; rd_add = $urandom;
    busy_pct = 0; stall_word = 7; stall_len = 3; rsp_wait = 5;
    build_exp(0, a, '0, '0);
    run_txn(0, a, 8'h9A, '0, '0);
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL stall count: got %0d want %0d", obs.size(), exp_q.size()); end
    checks++; if (stall_bad || rsp_bad || strobe_bad) begin errors++; $display("FAIL stall stability: stall %b rsp %b strobe %b want 0", stall_bad, rsp_bad, strobe_bad); end
    checks++; if (rsp_cycle !== 20) begin errors++; $display("FAIL stall rsp_cycle: got %0d want 20", rsp_cycle); end
    checks++; if (rsp_data_obs !== exp_line(a) || rsp_tag_obs !== 8'h9A) begin errors++; $display("FAIL stall data: got %h/%h want %h/9a", rsp_data_obs, rsp_tag_obs, exp_line(a)); end
    checks++; if (ready_cons !== 1'b0 || end_cycle !== 26 || ready_after !== 1'b1) begin errors++; $display("FAIL stall ready: cons %b end %0d after %b want 0 26 1", ready_cons, end_cycle, ready_after); end
    stall_len = 0; rsp_wait = 0;
  endtask

  task automatic test_reset_abort;
    logic [AW-1:0] a;
    bit rsp_seen;
    a = AW'($urandom); rd_xor = $urandom; rd_add = $urandom; rsp_seen = 0;
    mem_req_valid = 1; mem_req_rw = 0; mem_req_addr = a; mem_req_tag = 8'h77; gb_busy = 0;
    for (int c = 1; c <= 10; c++) begin @(negedge clk); if (c == 1) mem_req_valid = 0; end
    checks++; if (gb_ren !== 1'b1 || gb_addr !== {a, 4'd9, 2'b00}) begin errors++; $display("FAIL abort word9: ren %b addr %h want 1 %h", gb_ren, gb_addr, {a, 4'd9, 2'b00}); end
    reset = 1;
    #1;
    checks++; if ({gb_ren, gb_wen, busy, mem_rsp_valid, mem_req_ready} !== 5'b0) begin errors++; $display("FAIL abort async: got %b want 00000", {gb_ren, gb_wen, busy, mem_rsp_valid, mem_req_ready}); end
    checks++; if (mem_rsp_data !== '0) begin errors++; $display("FAIL abort rbuf: got %h want 0", mem_rsp_data); end
    repeat (2) @(negedge clk);
    reset = 0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (mem_rsp_valid) rsp_seen = 1; end
    checks++; if (rsp_seen || mem_req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort after: rsp %b ready %b busy %b want 0 1 0", rsp_seen, mem_req_ready, busy); end
    a = AW'($urandom);
    run_txn(0, a, 8'h78, '0, '0);
    checks++; if (rsp_data_obs !== exp_line(a) || rsp_tag_obs !== 8'h78 || rsp_cycle !== 17) begin errors++; $display("FAIL abort next read: got %h/%h @%0d want %h/78 @17", rsp_data_obs, rsp_tag_obs, rsp_cycle, exp_line(a)); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] d;
    bit ovl;
    for (int i = 0; i < LW; i++) d[32*i +: 32] = $urandom;
    rd_xor = $urandom; rd_add = $urandom; busy_pct = 0; stall_len = 0; rsp_wait = 0;
    nxt_rw = 0; nxt_addr = AW'($urandom); nxt_tag = 8'hB2; nxt_data = '0; nxt_byteen = '0;
    build_exp(1, 26'h3FF0, d, '1);
    chain = 1;
    run_txn(1, 26'h3FF0, 8'hB1, d, '1);
    chain = 0; ovl = strobe_bad;
    checks++; if (obs.size() != exp_q.size() || end_cycle !== 17) begin errors++; $display("FAIL b2b write: accesses %0d end %0d want %0d 17", obs.size(), end_cycle, exp_q.size()); end
    build_exp(0, nxt_addr, '0, '0);
    run_txn(0, nxt_addr, 8'hB2, '0, '0);
    checks++; if (wait_cycles !== 0) begin errors++; $display("FAIL b2b handshake gap: got %0d want 0", wait_cycles); end
    checks++; if (obs.size() != exp_q.size() || rsp_data_obs !== exp_line(nxt_addr) || rsp_tag_obs !== 8'hB2) begin errors++; $display("FAIL b2b read: got %h/%h want %h/b2", rsp_data_obs, rsp_tag_obs, exp_line(nxt_addr)); end
    checks++; if (ovl || strobe_bad) begin errors++; $display("FAIL b2b strobes: overlap %b %b want 0", ovl, strobe_bad); end
  endtask

  task automatic test_random;
    logic rw;
    logic [AW-1:0] a;
    logic [TW-1:0] t;
    logic [DW-1:0] d;
    logic [4*LW-1:0] be;
    for (int n = 0; n < 24; n++) begin
      rw = 1'($urandom); a = AW'($urandom); t = TW'($urandom);
      for (int i = 0; i < LW; i++) begin
        d[32*i +: 32] = $urandom;
        be[4*i +: 4] = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom);
      end
      rd_xor = $urandom; rd_add = $urandom; busy_pct = 30;
      stall_word = $urandom_range(LW-1); stall_len = $urandom_range(2); rsp_wait = $urandom_range(3);
      build_exp(rw, a, d, be);
      run_txn(rw, a, t, d, be);
      checks++; if (timeout || stall_bad || strobe_bad || rsp_bad) begin errors++; $display("FAIL rand%0d protocol: to %b stall %b strobe %b rsp %b", n, timeout, stall_bad, strobe_bad, rsp_bad); end
      checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d count: got %0d want %0d", n, obs.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin checks++; if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d acc%0d: got %h want %h", n, i, obs[i], exp_q[i]); end end
      checks++;
      if (rw ? got_rsp !== 1'b0 : (rsp_data_obs !== exp_line(a) || rsp_tag_obs !== t || !got_rsp)) begin
        errors++; $display("FAIL rand%0d rsp: rw %b got %b %h/%h want %h/%h", n, rw, got_rsp, rsp_data_obs, rsp_tag_obs, exp_line(a), t);
      end
    end
    busy_pct = 0; stall_len = 0; rsp_wait = 0;
  endtask

  initial begin
    test_reset;
    test_read_basic;
    test_write_full;
    test_write_sparse;
    test_stall_rsp;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
